serial_add_ctrl: RTL

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller: one full-adder bit per clock, LSB first,
// with a one-cycle done pulse and result/flag registers held until the next completion.
module serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             co_q, co_d;
  logic             ov_q, ov_d;

  logic             s_bit;
  logic             c_nxt;
  logic [WIDTH-1:0] res_shift;

  // Single full-adder slice shared by every bit position.
  assign s_bit     = a_q[0] ^ b_q[0] ^ c_q;
  assign c_nxt     = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  assign res_shift = {s_bit, res_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    co_d    = co_q;
    ov_d    = ov_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          c_d     = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = res_shift;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_nxt;
        if (cnt_q == LAST) begin
          sum_d   = res_shift;
          co_d    = c_nxt;
          ov_d    = c_q ^ c_nxt;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = co_q;
  assign overflow  = ov_q;

endmodule
